// File: rtl/cpu_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_gen_pkg
//  Purpose  : Shared opcodes, FSM state encoding and flag bit positions for
//             the parametrised accumulator CPU (cpu_core_gen).
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_gen_pkg;

    // Opcodes: instruction word is {op[3:0], imm[DATA_W-1:0]}
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_IN  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_SHL = 4'hC;
    localparam logic [3:0] OP_SHR = 4'hD;
    localparam logic [3:0] OP_MUL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Flag bit positions within {C,Z,V,N}
    localparam int F_C = 3;
    localparam int F_Z = 2;
    localparam int F_V = 1;
    localparam int F_N = 0;

endpackage
`default_nettype wire

// File: rtl/cpu_gen_alu.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_gen_alu
//  Purpose  : Combinational ALU for cpu_core_gen. Produces the result, the
//             candidate {C,Z,V,N} flags and a mask of which flags the opcode
//             updates. A set Z bit in the mask also means "write acc".
//  Config   : CPU_MUL_EN - when defined, opcode E is an unsigned multiply;
//             otherwise opcode E behaves as NOP and no multiplier exists.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_gen_alu
    import cpu_gen_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic [3:0]        o_flags,
    output logic [3:0]        o_upd
);

    localparam int         c_msb      = DATA_W - 1;
    localparam logic [3:0] c_upd_all  = 4'b1111;
    localparam logic [3:0] c_upd_zn   = 4'((1 << F_Z) | (1 << F_N));

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic            w_c;
    logic            w_v;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};   // msb set means borrow (a < b)

`ifdef CPU_MUL_EN
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod = i_a * i_b;
`endif

    // Result, carry/overflow and update mask per opcode
    always_comb begin
        o_result = i_a;
        w_c      = 1'b0;
        w_v      = 1'b0;
        o_upd    = 4'b0000;
        case (i_op)
            OP_LDI, OP_IN: begin
                o_result = i_b;
                o_upd    = c_upd_zn;
            end
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                w_c      = w_sum[DATA_W];
                w_v      = (i_a[c_msb] == i_b[c_msb]) && (w_sum[c_msb] != i_a[c_msb]);
                o_upd    = c_upd_all;
            end
            OP_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                w_c      = w_diff[DATA_W];
                w_v      = (i_a[c_msb] != i_b[c_msb]) && (w_diff[c_msb] != i_a[c_msb]);
                o_upd    = c_upd_all;
            end
            OP_AND: begin
                o_result = i_a & i_b;
                o_upd    = c_upd_all;
            end
            OP_OR: begin
                o_result = i_a | i_b;
                o_upd    = c_upd_all;
            end
            OP_XOR: begin
                o_result = i_a ^ i_b;
                o_upd    = c_upd_all;
            end
            OP_SHL: begin
                o_result = {i_a[DATA_W-2:0], 1'b0};
                w_c      = i_a[c_msb];
                o_upd    = c_upd_all;
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[DATA_W-1:1]};
                w_c      = i_a[0];
                o_upd    = c_upd_all;
            end
`ifdef CPU_MUL_EN
            OP_MUL: begin
                o_result = w_prod[DATA_W-1:0];
                w_c      = |w_prod[2*DATA_W-1:DATA_W];
                o_upd    = c_upd_all;
            end
`endif
            OP_NOP, OP_OUT, OP_JMP, OP_JZ, OP_JC, OP_HLT: ;
            default: ;
        endcase
    end

    // Assemble the flag vector from the selected result
    always_comb begin
        o_flags      = 4'b0000;
        o_flags[F_C] = w_c;
        o_flags[F_Z] = (o_result == '0);
        o_flags[F_V] = w_v;
        o_flags[F_N] = o_result[c_msb];
    end

endmodule
`default_nettype wire

// File: rtl/cpu_core_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_core_gen
//  Purpose  : Parametrised accumulator CPU with on-chip program RAM, a
//             run/halt control FSM (2 cycles per instruction), conditional
//             jumps and an output-valid strobe.
//  Config   : CPU_MUL_EN - enables opcode E (MUL) inside cpu_gen_alu.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_core_gen
    import cpu_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 run_i,
    input  logic                 prog_we_i,
    input  logic [PC_W-1:0]      prog_addr_i,
    input  logic [4+DATA_W-1:0]  prog_data_i,
    input  logic [DATA_W-1:0]    in_i,
    output logic [DATA_W-1:0]    out_o,
    output logic                 out_valid_o,
    output logic [3:0]           flags_o,
    output logic [PC_W-1:0]      pc_o,
    output logic                 halted_o
);

    localparam int IW    = 4 + DATA_W;
    localparam int DEPTH = 2 ** PC_W;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [IW-1:0]       r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_out;
    logic                r_out_valid;
    logic [3:0]          r_flags;
    logic [IW-1:0]       r_mem [DEPTH];

    logic [3:0]          w_op;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_alu_res;
    logic [3:0]          w_alu_flags;
    logic [3:0]          w_alu_upd;
    logic                w_take;

    assign w_op  = r_ir[IW-1 -: 4];
    assign w_imm = r_ir[DATA_W-1:0];
    assign w_b   = (w_op == OP_IN) ? in_i : w_imm;

    // Jumps test the flags left by the previous instruction
    assign w_take = (w_op == OP_JMP)
                 || ((w_op == OP_JZ) && r_flags[F_Z])
                 || ((w_op == OP_JC) && r_flags[F_C]);

    cpu_gen_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_op),
        .i_a      (r_acc),
        .i_b      (w_b),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags),
        .o_upd    (w_alu_upd)
    );

    // Program RAM: writable only while idle, never reset
    always_ff @(posedge clk_i) begin
        if ((r_state == ST_IDLE) && prog_we_i) begin
            r_mem[prog_addr_i] <= prog_data_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: run_i low aborts FETCH/EXEC and releases HALT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (run_i) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = run_i ? ST_EXEC : ST_IDLE;
            ST_EXEC: begin
                if (!run_i)               w_state_nxt = ST_IDLE;
                else if (w_op == OP_HLT)  w_state_nxt = ST_HALT;
                else                      w_state_nxt = ST_FETCH;
            end
            ST_HALT:  if (!run_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: instruction fetch, execute, pc sequencing and output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_flags     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (run_i) r_ir <= r_mem[r_pc];
                    else       r_pc <= '0;
                end
                ST_EXEC: begin
                    if (run_i) begin
                        // Every acc-writing opcode updates Z, so Z's mask bit doubles as acc enable
                        if (w_alu_upd[F_Z]) r_acc <= w_alu_res;
                        r_flags <= (r_flags & ~w_alu_upd) | (w_alu_flags & w_alu_upd);
                        if (w_op == OP_OUT) begin
                            r_out       <= r_acc;
                            r_out_valid <= 1'b1;
                        end
                        r_pc <= w_take ? w_imm[PC_W-1:0] : r_pc + PC_W'(1);
                    end else begin
                        r_pc <= '0;
                    end
                end
                ST_HALT: begin
                    if (!run_i) r_pc <= '0;
                end
                default: ;
            endcase
        end
    end

    assign out_o       = r_out;
    assign out_valid_o = r_out_valid;
    assign flags_o     = r_flags;
    assign pc_o        = r_pc;
    assign halted_o    = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_core_gen
//  Purpose  : Self-checking bench for cpu_core_gen (DATA_W=8, PC_W=4).
//             Honours CPU_MUL_EN for the opcode-E expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_core_gen;
    import cpu_gen_pkg::*;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int IW = 4 + DW;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          run     = 1'b0;
    logic          we      = 1'b0;
    logic [PW-1:0] addr    = '0;
    logic [IW-1:0] wdata   = '0;
    logic [DW-1:0] in_v    = '0;
    logic [DW-1:0] out_o;
    logic          out_valid;
    logic [3:0]    flags;
    logic [PW-1:0] pc;
    logic          halted;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] sb[$];

    typedef struct packed {
        logic [15:0][IW-1:0] prog;
        logic [DW-1:0]       in_val;
        logic [1:0]          n_out;
        logic [DW-1:0]       out0;
        logic [DW-1:0]       out1;
        logic [3:0]          flags;
        logic [PW-1:0]       hpc;
    } vec_t;

    vec_t vecs[$];

    cpu_core_gen #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .run_i       (run),
        .prog_we_i   (we),
        .prog_addr_i (addr),
        .prog_data_i (wdata),
        .in_i        (in_v),
        .out_o       (out_o),
        .out_valid_o (out_valid),
        .flags_o     (flags),
        .pc_o        (pc),
        .halted_o    (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [DW-1:0] imm);
        return {op, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected value
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_out_valid: got pulse with out 0x%0h, required none", out_o);
            end else begin
                chk("sb_out", {24'd0, out_o}, {24'd0, sb.pop_front()});
            end
        end
    end

    // Write words 1..15, then word 0 in the same cycle run rises
    task automatic load_run(input logic [15:0][IW-1:0] p);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            we = 1'b1; addr = PW'(k); wdata = p[k];
        end
        @(negedge clk);
        addr = '0; wdata = p[0]; run = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_halt(input int bound, output int cyc);
        cyc = 0;
        while (!halted && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_sb_empty(input int bound);
        int c;
        c = 0;
        while (sb.size() != 0 && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic add(input logic [15:0][IW-1:0] p, input logic [DW-1:0] iv, input logic [1:0] n,
                       input logic [DW-1:0] o0, input logic [DW-1:0] o1,
                       input logic [3:0] f, input logic [PW-1:0] h);
        vec_t v;
        v.prog = p; v.in_val = iv; v.n_out = n; v.out0 = o0; v.out1 = o1; v.flags = f; v.hpc = h;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0][IW-1:0] p;
        int cyc;

        // ---------------- vector table (flags are {C,Z,V,N}, carried between runs) ----------
        p = '0; p[0]=ins(OP_LDI,8'h05); p[1]=ins(OP_ADD,8'h03); p[2]=ins(OP_OUT,0); p[3]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h08, 8'h00, 4'b0000, 4'd4);
        p = '0; p[0]=ins(OP_LDI,8'h7F); p[1]=ins(OP_ADD,8'h01); p[2]=ins(OP_OUT,0); p[3]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h80, 8'h00, 4'b0011, 4'd4);
        p = '0; p[0]=ins(OP_LDI,8'h00); p[1]=ins(OP_SUB,8'h01); p[2]=ins(OP_OUT,0); p[3]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'hFF, 8'h00, 4'b1001, 4'd4);
        p = '0; p[0]=ins(OP_LDI,8'h80); p[1]=ins(OP_SUB,8'h01); p[2]=ins(OP_OUT,0); p[3]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h7F, 8'h00, 4'b0010, 4'd4);
        p = '0; p[0]=ins(OP_LDI,8'hFF); p[1]=ins(OP_ADD,8'h01); p[2]=ins(OP_LDI,8'h80); p[3]=ins(OP_OUT,0); p[4]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h80, 8'h00, 4'b1001, 4'd5);
        p = '0; p[0]=ins(OP_LDI,8'hFF); p[1]=ins(OP_ADD,8'h01); p[2]=ins(OP_LDI,8'hF0); p[3]=ins(OP_AND,8'h3C);
        p[4]=ins(OP_OUT,0); p[5]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h30, 8'h00, 4'b0000, 4'd6);
        p = '0; p[0]=ins(OP_LDI,8'h0F); p[1]=ins(OP_OR,8'hF0); p[2]=ins(OP_XOR,8'h0F); p[3]=ins(OP_OUT,0); p[4]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'hF0, 8'h00, 4'b0001, 4'd5);
        p = '0; p[0]=ins(OP_LDI,8'h81); p[1]=ins(OP_SHL,8'h00); p[2]=ins(OP_OUT,0); p[3]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h02, 8'h00, 4'b1000, 4'd4);
        p = '0; p[0]=ins(OP_LDI,8'h81); p[1]=ins(OP_SHR,8'h00); p[2]=ins(OP_OUT,0); p[3]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h40, 8'h00, 4'b1000, 4'd4);
        p = '0; p[0]=ins(OP_IN,8'h00); p[1]=ins(OP_OUT,0); p[2]=ins(OP_HLT,0);
        add(p, 8'hA5, 2'd1, 8'hA5, 8'h00, 4'b1001, 4'd3);
        // JZ taken / not taken
        p = '0; p[0]=ins(OP_LDI,8'h00); p[1]=ins(OP_JZ,8'h06); p[2]=ins(OP_LDI,8'h01); p[3]=ins(OP_OUT,0); p[4]=ins(OP_HLT,0);
        p[6]=ins(OP_LDI,8'h09); p[7]=ins(OP_OUT,0); p[8]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h09, 8'h00, 4'b1000, 4'd9);
        p = '0; p[0]=ins(OP_LDI,8'h01); p[1]=ins(OP_JZ,8'h06); p[2]=ins(OP_LDI,8'h02); p[3]=ins(OP_OUT,0); p[4]=ins(OP_HLT,0);
        p[6]=ins(OP_LDI,8'h09); p[7]=ins(OP_OUT,0); p[8]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h02, 8'h00, 4'b1000, 4'd5);
        // JC taken / not taken
        p = '0; p[0]=ins(OP_LDI,8'hFF); p[1]=ins(OP_ADD,8'h01); p[2]=ins(OP_JC,8'h07); p[3]=ins(OP_LDI,8'h03);
        p[4]=ins(OP_OUT,0); p[5]=ins(OP_HLT,0); p[7]=ins(OP_OUT,0); p[8]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h00, 8'h00, 4'b1100, 4'd9);
        p = '0; p[0]=ins(OP_LDI,8'h01); p[1]=ins(OP_ADD,8'h01); p[2]=ins(OP_JC,8'h07); p[3]=ins(OP_OUT,0); p[4]=ins(OP_HLT,0);
        p[7]=ins(OP_LDI,8'h09); p[8]=ins(OP_OUT,0); p[9]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h02, 8'h00, 4'b0000, 4'd5);
        // JMP, then two OUT pulses in one program
        p = '0; p[0]=ins(OP_JMP,8'h05); p[1]=ins(OP_LDI,8'h03); p[2]=ins(OP_OUT,0); p[3]=ins(OP_HLT,0);
        p[5]=ins(OP_LDI,8'h04); p[6]=ins(OP_OUT,0); p[7]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd1, 8'h04, 8'h00, 4'b0000, 4'd8);
        p = '0; p[0]=ins(OP_LDI,8'h01); p[1]=ins(OP_OUT,0); p[2]=ins(OP_ADD,8'h01); p[3]=ins(OP_OUT,0); p[4]=ins(OP_HLT,0);
        add(p, 8'h00, 2'd2, 8'h01, 8'h02, 4'b0000, 4'd5);
        // Opcode E: 0x20 * 0x10 = 0x200
        p = '0; p[0]=ins(OP_LDI,8'hFF); p[1]=ins(OP_ADD,8'h01); p[2]=ins(OP_LDI,8'h20); p[3]=ins(OP_MUL,8'h10);
        p[4]=ins(OP_OUT,0); p[5]=ins(OP_HLT,0);
`ifdef CPU_MUL_EN
        add(p, 8'h00, 2'd1, 8'h00, 8'h00, 4'b1100, 4'd6);
`else
        add(p, 8'h00, 2'd1, 8'h20, 8'h00, 4'b1000, 4'd6);
`endif

        // ---------------- reset state ----------------
        #12;
        chk("rst_out",    {24'd0, out_o}, 32'd0);
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_flags",  {28'd0, flags}, 32'd0);
        chk("rst_pc",     {28'd0, pc}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven runs ----------------
        foreach (vecs[i]) begin
            sb.push_back(vecs[i].out0);
            if (vecs[i].n_out == 2'd2) sb.push_back(vecs[i].out1);
            in_v = vecs[i].in_val;
            load_run(vecs[i].prog);
            wait_halt(60, cyc);
            if (i == 0) chk("halt_latency", cyc, 32'd8);
            chk($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].flags});
            chk($sformatf("v%0d_pc", i),    {28'd0, pc},    {28'd0, vecs[i].hpc});
            chk($sformatf("v%0d_out", i),   {24'd0, out_o},
                {24'd0, (vecs[i].n_out == 2'd2) ? vecs[i].out1 : vecs[i].out0});
            chk($sformatf("v%0d_sb", i), sb.size(), 32'd0);
            run = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_unhalt", i), {31'd0, halted}, 32'd0);
        end

        // ---------------- write while halted is ignored ----------------
        sb.push_back(8'h08);
        load_run(vecs[0].prog);
        wait_halt(60, cyc);
        we = 1'b1; addr = '0; wdata = ins(OP_LDI, 8'hEE);
        @(negedge clk);
        we = 1'b0;
        run = 1'b0;
        @(negedge clk);
        sb.push_back(8'h08);
        run = 1'b1;
        wait_halt(60, cyc);
        chk("halt_write_ignored", {24'd0, out_o}, 32'h08);
        chk("halt_write_sb", sb.size(), 32'd0);
        run = 1'b0;
        @(negedge clk);

        // ---------------- pc wrap 15 -> 0 ----------------
        p = '0; p[0] = ins(OP_IN, 8'h00); p[1] = ins(OP_OUT, 0);
        in_v = 8'h11;
        sb.push_back(8'h11);
        load_run(p);
        cyc = 0;
        while (pc != 4'd15 && cyc < 60) begin @(negedge clk); cyc++; end
        chk("wrap_pc15", {28'd0, pc}, 32'd15);
        in_v = 8'h22;
        sb.push_back(8'h22);
        cyc = 0;
        while (pc != 4'd0 && cyc < 10) begin @(negedge clk); cyc++; end
        chk("wrap_pc0", {28'd0, pc}, 32'd0);
        wait_sb_empty(20);
        run = 1'b0;
        @(negedge clk);

        // ---------------- run dropped during EXEC of OUT ----------------
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        p = '0; p[0] = ins(OP_LDI, 8'h05); p[1] = ins(OP_OUT, 0); p[2] = ins(OP_HLT, 0);
        load_run(p);
        repeat (3) @(negedge clk);      // now in EXEC of OUT
        run = 1'b0;
        @(negedge clk);
        chk("abort_valid",  {31'd0, out_valid}, 32'd0);
        chk("abort_pc",     {28'd0, pc}, 32'd0);
        chk("abort_out",    {24'd0, out_o}, 32'd0);
        chk("abort_halted", {31'd0, halted}, 32'd0);
        sb.push_back(8'h05);
        run = 1'b1;
        wait_halt(60, cyc);
        chk("abort_rerun_sb", sb.size(), 32'd0);
        run = 1'b0;
        @(negedge clk);

        // ---------------- asynchronous reset mid-run ----------------
        p = '0; p[0] = ins(OP_LDI, 8'h80); p[1] = ins(OP_OUT, 0); p[2] = ins(OP_NOP, 0); p[3] = ins(OP_JMP, 8'h02);
        sb.push_back(8'h80);
        load_run(p);
        wait_sb_empty(30);
        chk("prereset_flags", {28'd0, flags}, 32'b0001);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out",    {24'd0, out_o}, 32'd0);
        chk("arst_valid",  {31'd0, out_valid}, 32'd0);
        chk("arst_flags",  {28'd0, flags}, 32'd0);
        chk("arst_pc",     {28'd0, pc}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
